// File: rtl/ternary_seq_pkg.sv
// Shared definitions for the ternary term-summing sequencer.
// Holds the FSM state encoding and the per-job term limit.
package ternary_seq_pkg;

   localparam int MAX_TERMS = 9;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ternary_sum_seq.sv
// Sums up to MAX_TERMS unsigned terms per job through one shared three-operand adder.
// Terms are staged two at a time in holding registers, then folded into the accumulator.
module ternary_sum_seq
   import ternary_seq_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MAX_TERMS = ternary_seq_pkg::MAX_TERMS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH+3:0] out_sum,
   output logic [3:0]       out_count,
   output logic             out_err
);

   state_t           r_state;
   logic [WIDTH+3:0] r_acc;
   logic [3:0]       r_count;
   logic             r_err;
   logic             r_lastSeen;
   logic [WIDTH-1:0] r_h0;
   logic [WIDTH-1:0] r_h1;
   logic             r_h0Full;
   logic             r_h1Full;

   logic             w_accept;
   logic             w_store;
   logic [WIDTH+3:0] w_op0;
   logic [WIDTH+3:0] w_op1;
   logic [WIDTH+3:0] w_sum;

   assign w_accept = in_valid && (r_state == FILL);
   assign w_store  = r_count < 4'(MAX_TERMS);

   // The only adder on the term path; empty holding registers contribute zero.
   assign w_op0 = r_h0Full ? {4'b0000, r_h0} : '0;
   assign w_op1 = r_h1Full ? {4'b0000, r_h1} : '0;
   assign w_sum = r_acc + w_op0 + w_op1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= FILL;
         r_acc      <= '0;
         r_count    <= '0;
         r_err      <= 1'b0;
         r_lastSeen <= 1'b0;
         r_h0       <= '0;
         r_h1       <= '0;
         r_h0Full   <= 1'b0;
         r_h1Full   <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  // Beats past the term limit are swallowed but flag the job.
                  if (w_store) begin
                     r_count <= r_count + 4'd1;
                     if (!r_h0Full) begin
                        r_h0     <= in_data;
                        r_h0Full <= 1'b1;
                     end else begin
                        r_h1     <= in_data;
                        r_h1Full <= 1'b1;
                     end
                  end else begin
                     r_err <= 1'b1;
                  end
                  if (in_last) begin
                     r_lastSeen <= 1'b1;
                  end
                  if (in_last || (w_store && r_h0Full)) begin
                     r_state <= ADD;
                  end
               end
            end
            ADD: begin
               r_acc    <= w_sum;
               r_h0     <= '0;
               r_h1     <= '0;
               r_h0Full <= 1'b0;
               r_h1Full <= 1'b0;
               r_state  <= r_lastSeen ? DONE : FILL;
            end
            DONE: begin
               if (out_ready) begin
                  r_state    <= FILL;
                  r_acc      <= '0;
                  r_count    <= '0;
                  r_err      <= 1'b0;
                  r_lastSeen <= 1'b0;
               end
            end
            default: begin
               r_state <= FILL;
            end
         endcase
      end
   end

   // Handshake flags come straight from the state register; result fields are masked outside DONE.
   assign in_ready  = (r_state == FILL);
   assign out_valid = (r_state == DONE);
   assign out_sum   = out_valid ? r_acc   : '0;
   assign out_count = out_valid ? r_count : '0;
   assign out_err   = out_valid ? r_err   : 1'b0;

endmodule

// File: tb/tb_ternary_sum_seq.sv
// Directed self-checking bench for ternary_sum_seq at WIDTH=8.
// Expected sums, counts and timing are hand-computed constants.
module tb_ternary_sum_seq;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH+3:0] out_sum;
   logic [3:0]       out_count;
   logic             out_err;

   int total;
   int bad;

   ternary_sum_seq #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_count(out_count),
      .out_err  (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Offers one beat and returns one sample point after the edge that accepted it.
   task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic last);
      int waitCycles;
      waitCycles = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (in_ready !== 1'b1 && waitCycles < 20) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      checkOutput("beatAccepted", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic waitResult(input string tag);
      int waitCycles;
      waitCycles = 0;
      while (out_valid !== 1'b1 && waitCycles < 20) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      checkOutput({tag, "_valid"}, int'(out_valid), 1);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      stepCycle();
      stepCycle();
      rst = 1'b0;

      checkOutput("rst_outValid", int'(out_valid), 0);
      checkOutput("rst_inReady",  int'(in_ready),  1);
      checkOutput("rst_outSum",   int'(out_sum),   0);
      checkOutput("rst_outCount", int'(out_count), 0);
      checkOutput("rst_outErr",   int'(out_err),   0);

      // Nine maximal terms back to back: the widest exact sum.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(8'd255, (i == 8));
      end
      waitResult("nine255");
      checkOutput("nine255_sum",   int'(out_sum),   2295);
      checkOutput("nine255_count", int'(out_count), 9);
      checkOutput("nine255_err",   int'(out_err),   0);
      stepCycle();
      checkOutput("nine255_singlePulse", int'(out_valid), 0);
      checkOutput("nine255_sumCleared",  int'(out_sum),   0);

      // Single-beat job: ADD one cycle after acceptance, result the cycle after.
      applyStimulus(8'd7, 1'b1);
      checkOutput("single_addNotValid", int'(out_valid), 0);
      checkOutput("single_addNotReady", int'(in_ready),  0);
      stepCycle();
      checkOutput("single_latencyValid", int'(out_valid), 1);
      checkOutput("single_sum",          int'(out_sum),   7);
      checkOutput("single_count",        int'(out_count), 1);
      checkOutput("single_err",          int'(out_err),   0);
      stepCycle();

      // Eleven ones: two overflow beats are accepted but only nine are summed.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(8'd1, (i == 10));
      end
      waitResult("eleven");
      checkOutput("eleven_sum",   int'(out_sum),   9);
      checkOutput("eleven_count", int'(out_count), 9);
      checkOutput("eleven_err",   int'(out_err),   1);
      stepCycle();

      // Error flag must not leak into the next job.
      applyStimulus(8'd100, 1'b0);
      applyStimulus(8'd200, 1'b1);
      waitResult("pair");
      checkOutput("pair_sum",   int'(out_sum),   300);
      checkOutput("pair_count", int'(out_count), 2);
      checkOutput("pair_err",   int'(out_err),   0);
      stepCycle();

      // Backpressure: result held while the consumer stalls.
      out_ready = 1'b0;
      applyStimulus(8'd1, 1'b0);
      applyStimulus(8'd2, 1'b1);
      waitResult("stall");
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         checkOutput("stall_valid",   int'(out_valid), 1);
         checkOutput("stall_sum",     int'(out_sum),   3);
         checkOutput("stall_count",   int'(out_count), 2);
         checkOutput("stall_inReady", int'(in_ready),  0);
      end
      out_ready = 1'b1;
      stepCycle();
      checkOutput("stall_released",  int'(out_valid), 0);
      checkOutput("stall_nextReady", int'(in_ready),  1);

      // Reset in the middle of a job drops it without a result.
      applyStimulus(8'd5, 1'b0);
      applyStimulus(8'd6, 1'b0);
      applyStimulus(8'd7, 1'b0);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("midRst_outValid", int'(out_valid), 0);
      checkOutput("midRst_inReady",  int'(in_ready),  1);
      applyStimulus(8'd1, 1'b0);
      applyStimulus(8'd2, 1'b0);
      applyStimulus(8'd3, 1'b1);
      waitResult("afterRst");
      checkOutput("afterRst_sum",   int'(out_sum),   6);
      checkOutput("afterRst_count", int'(out_count), 3);
      checkOutput("afterRst_err",   int'(out_err),   0);
      stepCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
